// File: rtl/demux12_size4_fifo.sv
// 1:2 stream demultiplexer with a DEPTH-entry FIFO per output lane.
// Optional per-lane transfer counters are enabled by defining DEMUX12_XFER_CNT_EN.
module demux12_size4_fifo #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] IN0,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic             CTRL,
  output logic [WIDTH-1:0] OUT0,
  output logic             OUT0_VALID,
  input  logic             OUT0_READY,
  output logic [WIDTH-1:0] OUT1,
  output logic             OUT1_VALID,
  input  logic             OUT1_READY,
  output logic [CNT_W-1:0] CNT0,
  output logic [CNT_W-1:0] CNT1
);

  localparam int unsigned PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W    = PTR_W + 1;
  localparam int unsigned NUM_LANE = 2;

  logic [WIDTH-1:0] mem_q    [NUM_LANE][DEPTH];
  logic [WIDTH-1:0] mem_d    [NUM_LANE][DEPTH];
  logic [PTR_W-1:0] wr_ptr_q [NUM_LANE];
  logic [PTR_W-1:0] wr_ptr_d [NUM_LANE];
  logic [PTR_W-1:0] rd_ptr_q [NUM_LANE];
  logic [PTR_W-1:0] rd_ptr_d [NUM_LANE];
  logic [OCC_W-1:0] count_q  [NUM_LANE];
  logic [OCC_W-1:0] count_d  [NUM_LANE];
  logic [WIDTH-1:0] out_q    [NUM_LANE];
  logic [WIDTH-1:0] out_d    [NUM_LANE];

  logic [NUM_LANE-1:0] full_c;
  logic [NUM_LANE-1:0] push_c;
  logic [NUM_LANE-1:0] pop_c;
  logic [NUM_LANE-1:0] out_ready_c;
  logic                in_ready_c;

  assign out_ready_c = {OUT1_READY, OUT0_READY};
  assign in_ready_c  = ~full_c[CTRL];

  // Handshake decode per lane
  always_comb begin
    full_c = '0;
    push_c = '0;
    pop_c  = '0;
    for (int n = 0; n < NUM_LANE; n++) begin
      full_c[n] = (count_q[n] == OCC_W'(DEPTH));
      push_c[n] = IN_VALID & in_ready_c & (CTRL == 1'(n));
      pop_c[n]  = (count_q[n] != '0) & out_ready_c[n];
    end
  end

  // FIFO next state; the head register reloads only on a pop or a push into an empty lane
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    out_d    = out_q;
    for (int n = 0; n < NUM_LANE; n++) begin
      if (push_c[n]) begin
        mem_d[n][wr_ptr_q[n]] = IN0;
        wr_ptr_d[n]           = wr_ptr_q[n] + PTR_W'(1);
      end
      if (pop_c[n]) begin
        rd_ptr_d[n] = rd_ptr_q[n] + PTR_W'(1);
      end
      case ({push_c[n], pop_c[n]})
        2'b10:   count_d[n] = count_q[n] + OCC_W'(1);
        2'b01:   count_d[n] = count_q[n] - OCC_W'(1);
        default: count_d[n] = count_q[n];
      endcase
      if (pop_c[n] || (push_c[n] && (count_q[n] == '0))) begin
        out_d[n] = mem_d[n][rd_ptr_d[n]];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int n = 0; n < NUM_LANE; n++) begin
        for (int i = 0; i < DEPTH; i++) begin
          mem_q[n][i] <= '0;
        end
        wr_ptr_q[n] <= '0;
        rd_ptr_q[n] <= '0;
        count_q[n]  <= '0;
        out_q[n]    <= '0;
      end
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      out_q    <= out_d;
    end
  end

  assign IN_READY   = in_ready_c;
  assign OUT0       = out_q[0];
  assign OUT1       = out_q[1];
  assign OUT0_VALID = (count_q[0] != '0);
  assign OUT1_VALID = (count_q[1] != '0);

`ifdef DEMUX12_XFER_CNT_EN
  logic [CNT_W-1:0] cnt_q [NUM_LANE];
  logic [CNT_W-1:0] cnt_d [NUM_LANE];

  // Free-running accepted-word counters, wrap silently
  always_comb begin
    for (int n = 0; n < NUM_LANE; n++) begin
      cnt_d[n] = cnt_q[n] + CNT_W'(push_c[n]);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int n = 0; n < NUM_LANE; n++) begin
        cnt_q[n] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign CNT0 = cnt_q[0];
  assign CNT1 = cnt_q[1];
`else
  assign CNT0 = '0;
  assign CNT1 = '0;
`endif

endmodule

// File: tb/tb_demux12_size4_fifo.sv
// Directed self-checking bench for demux12_size4_fifo (counter checks follow DEMUX12_XFER_CNT_EN).
module tb_demux12_size4_fifo;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 4;

  logic             CLK;
  logic             RST;
  logic [WIDTH-1:0] IN0;
  logic             IN_VALID;
  logic             IN_READY;
  logic             CTRL;
  logic [WIDTH-1:0] OUT0;
  logic             OUT0_VALID;
  logic             OUT0_READY;
  logic [WIDTH-1:0] OUT1;
  logic             OUT1_VALID;
  logic             OUT1_READY;
  logic [CNT_W-1:0] CNT0;
  logic [CNT_W-1:0] CNT1;

  int checks;
  int errors;
  int exp_cnt0;
  int exp_cnt1;

  demux12_size4_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .IN0        (IN0),
    .IN_VALID   (IN_VALID),
    .IN_READY   (IN_READY),
    .CTRL       (CTRL),
    .OUT0       (OUT0),
    .OUT0_VALID (OUT0_VALID),
    .OUT0_READY (OUT0_READY),
    .OUT1       (OUT1),
    .OUT1_VALID (OUT1_VALID),
    .OUT1_READY (OUT1_READY),
    .CNT0       (CNT0),
    .CNT1       (CNT1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] exp_cnt(input int c);
`ifdef DEMUX12_XFER_CNT_EN
    return 32'(c % (1 << CNT_W));
`else
    return 32'(c * 0);
`endif
  endfunction

  task automatic check_cnts(input string tag);
    check({tag, "_cnt0"}, 32'(CNT0), exp_cnt(exp_cnt0));
    check({tag, "_cnt1"}, 32'(CNT1), exp_cnt(exp_cnt1));
  endtask

  // Present one word and clock it in; caller guarantees IN_READY for the chosen lane
  task automatic push(input logic ctrl, input logic [WIDTH-1:0] data);
    IN_VALID = 1'b1;
    CTRL     = ctrl;
    IN0      = data;
    #1;
    check("push_ready", 32'(IN_READY), 32'd1);
    if (ctrl) exp_cnt1++;
    else      exp_cnt0++;
    step();
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    exp_cnt0   = 0;
    exp_cnt1   = 0;
    RST        = 1'b1;
    IN0        = '0;
    IN_VALID   = 1'b0;
    CTRL       = 1'b0;
    OUT0_READY = 1'b0;
    OUT1_READY = 1'b0;
    step();
    step();
    RST = 1'b0;
    #1;
    check("rst_v0",    32'(OUT0_VALID), 32'd0);
    check("rst_v1",    32'(OUT1_VALID), 32'd0);
    check("rst_out0",  32'(OUT0),       32'd0);
    check("rst_out1",  32'(OUT1),       32'd0);
    check("rst_ready", 32'(IN_READY),   32'd1);
    check_cnts("rst");

    // Single word to lane 0 with both consumers ready
    OUT0_READY = 1'b1;
    OUT1_READY = 1'b1;
    push(1'b0, 4'hA);
    IN_VALID = 1'b0;
    #1;
    check("lat_out0", 32'(OUT0),       32'hA);
    check("lat_v0",   32'(OUT0_VALID), 32'd1);
    check("lat_v1",   32'(OUT1_VALID), 32'd0);
    check_cnts("lat");
    step();
    check("lat_drain_v0", 32'(OUT0_VALID), 32'd0);

    // Fill lane 0, then redirect to lane 1
    OUT0_READY = 1'b0;
    OUT1_READY = 1'b0;
    push(1'b0, 4'h1);
    check("fill_out0", 32'(OUT0), 32'h1);
    push(1'b0, 4'h2);
    IN_VALID = 1'b1;
    CTRL     = 1'b0;
    IN0      = 4'h5;
    #1;
    check("full0_ready", 32'(IN_READY), 32'd0);
    CTRL = 1'b1;
    #1;
    check("free1_ready", 32'(IN_READY), 32'd1);
    push(1'b1, 4'h3);
    check("l1_out1", 32'(OUT1),       32'h3);
    check("l1_v1",   32'(OUT1_VALID), 32'd1);
    check("l1_out0", 32'(OUT0),       32'h1);
    check("l1_v0",   32'(OUT0_VALID), 32'd1);

    // Pop from full lane does not open IN_READY in the same cycle
    OUT0_READY = 1'b1;
    IN_VALID   = 1'b1;
    CTRL       = 1'b0;
    IN0        = 4'h4;
    #1;
    check("nopass_ready", 32'(IN_READY), 32'd0);
    step();
    check("after_pop_out0",  32'(OUT0),     32'h2);
    check("after_pop_ready", 32'(IN_READY), 32'd1);
    push(1'b0, 4'h4);
    check("pp1_out0", 32'(OUT0),       32'h4);
    check("pp1_v0",   32'(OUT0_VALID), 32'd1);
    push(1'b0, 4'h6);
    check("pp2_out0",  32'(OUT0),       32'h6);
    check("pp2_v0",    32'(OUT0_VALID), 32'd1);
    check("pp2_ready", 32'(IN_READY),   32'd1);
    IN_VALID   = 1'b0;
    OUT1_READY = 1'b1;
    step();
    check("drain_v0", 32'(OUT0_VALID), 32'd0);
    check("drain_v1", 32'(OUT1_VALID), 32'd0);
    check_cnts("drain");

    // Interleaved lanes, consumers always ready
    push(1'b0, 4'h1);
    check("il_out0_a", 32'(OUT0), 32'h1);
    push(1'b1, 4'h2);
    check("il_out1_a", 32'(OUT1),       32'h2);
    check("il_v0_a",   32'(OUT0_VALID), 32'd0);
    push(1'b0, 4'h3);
    check("il_out0_b", 32'(OUT0),       32'h3);
    check("il_v1_b",   32'(OUT1_VALID), 32'd0);
    push(1'b1, 4'h4);
    check("il_out1_b", 32'(OUT1),       32'h4);
    check("il_v0_b",   32'(OUT0_VALID), 32'd0);
    IN_VALID = 1'b0;
    step();
    check("il_v0_end", 32'(OUT0_VALID), 32'd0);
    check("il_v1_end", 32'(OUT1_VALID), 32'd0);

    // Fill both lanes, then reset mid-operation
    OUT0_READY = 1'b0;
    OUT1_READY = 1'b0;
    push(1'b0, 4'h7);
    push(1'b0, 4'h8);
    push(1'b1, 4'h9);
    push(1'b1, 4'hB);
    IN_VALID = 1'b1;
    CTRL     = 1'b0;
    #1;
    check("both_full_r0", 32'(IN_READY), 32'd0);
    CTRL = 1'b1;
    #1;
    check("both_full_r1", 32'(IN_READY), 32'd0);
    check("both_full_out1", 32'(OUT1), 32'h9);
    check_cnts("full");
    IN_VALID   = 1'b0;
    OUT0_READY = 1'b1;
    OUT1_READY = 1'b1;
    RST        = 1'b1;
    step();
    RST        = 1'b0;
    OUT0_READY = 1'b0;
    OUT1_READY = 1'b0;
    exp_cnt0   = 0;
    exp_cnt1   = 0;
    #1;
    check("mrst_v0",    32'(OUT0_VALID), 32'd0);
    check("mrst_v1",    32'(OUT1_VALID), 32'd0);
    check("mrst_out0",  32'(OUT0),       32'd0);
    check("mrst_out1",  32'(OUT1),       32'd0);
    check("mrst_ready", 32'(IN_READY),   32'd1);
    check_cnts("mrst");

    // Seventeen words to lane 1 wraps the 4-bit counter
    OUT1_READY = 1'b1;
    for (int i = 0; i < 17; i++) begin
      push(1'b1, 4'(i));
      check("wrap_out1", 32'(OUT1), 32'(i % 16));
    end
    IN_VALID = 1'b0;
    step();
    check("wrap_v1", 32'(OUT1_VALID), 32'd0);
    check_cnts("wrap");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux12_size4_fifo.md
Name: demux12_size4_fifo

Overview:
- Stream 1:2 demultiplexer; the inverse of the 2:1 word mux. One input stream goes to one of two output streams, selected per word by CTRL.
- Each output lane has a DEPTH-entry FIFO, so a stalled lane never blocks the other lane when CTRL selects the free one.
- Sits upstream of the 2:1 mux path. It fans a single producer out to two consumers using valid/ready handshakes.

Parameters:
- WIDTH, 4, data word width in bits.
- DEPTH, 2, entries per output FIFO; power of two, at least 2.
- CNT_W, 16, width of the transfer counters (used only with the optional feature).

Ports:
- CLK  input  1  single clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- IN0  input  WIDTH  input data word.
- IN_VALID  input  1  input word valid.
- IN_READY  output  1  block can accept the word on IN0 this cycle.
- CTRL  input  1  destination of the current input word: 0 -> lane 0, 1 -> lane 1.
- OUT0  output  WIDTH  lane 0 head-of-FIFO data.
- OUT0_VALID  output  1  lane 0 holds at least one word.
- OUT0_READY  input  1  lane 0 consumer accepts OUT0.
- OUT1  output  WIDTH  lane 1 head-of-FIFO data.
- OUT1_VALID  output  1  lane 1 holds at least one word.
- OUT1_READY  input  1  lane 1 consumer accepts OUT1.
- CNT0  output  CNT_W  lane 0 words accepted into FIFO (optional feature only).
- CNT1  output  CNT_W  lane 1 words accepted into FIFO (optional feature only).

Behaviour:
- Reset (RST=1 at a clock edge):
  - Both FIFO occupancies go to 0; read/write pointers go to 0; storage clears to 0.
  - OUT0_VALID=0, OUT1_VALID=0, OUT0=0, OUT1=0.
  - IN_READY is 1 in the first cycle after reset.
  - Reset mid-operation discards all buffered words; no output handshake completes in the reset cycle.
- Push: push_n = IN_VALID & IN_READY & (CTRL==n).
  - IN_READY = !full[CTRL], and is combinational on CTRL.
  - There is no same-cycle pass-through on a full lane. A pop from a full lane makes room from the next cycle only.
- Pop: pop_n = OUTn_VALID & OUTn_READY.
  - OUTn_VALID = (count_n != 0).
  - OUTn is the registered head entry. It changes only on the clock edge after a pop or a push into an empty lane.
- Latency: an input word accepted in cycle t appears at OUTn with OUTn_VALID=1 in cycle t+1 when lane n was empty.
- Occupancy per lane (count width clog2(DEPTH)+1):
  - push only: +1.
  - pop only: -1.
  - push and pop in the same cycle: unchanged; the pointers still advance.
  - neither: hold.
- Ordering: FIFO order is preserved within each lane. No ordering guarantee exists between lanes.
- Pointers wrap modulo DEPTH.
- Full: count_n == DEPTH. Empty: count_n == 0.
- Lane independence: a full lane 0 with CTRL=1 still accepts into lane 1 if lane 1 is not full.
- CTRL:
  - Only meaningful when IN_VALID=1.
  - May change while IN_VALID=1 and IN_READY=0. IN_READY then re-evaluates against the newly selected lane.
- OUTn_VALID never deasserts without a pop or reset.
- OUTn stays stable while OUTn_VALID=1 and OUTn_READY=0.
- IN0 and CTRL are don't-care when IN_VALID=0.

Optional Feature:
- Macro: DEMUX12_XFER_CNT_EN.
- Defined:
  - CNT0 and CNT1 are registered counters, cleared to 0 by RST.
  - Each increments by 1 on push_0 / push_1 respectively.
  - Each wraps from 2^CNT_W-1 to 0 with no saturation and no flag.
- Not defined: CNT0 and CNT1 are tied to 0 and no counter flops are synthesized. The ports remain present.

Test Plan:
- Reset, then IN_VALID=1, CTRL=0, IN0=4'hA, both READY=1 -> next cycle OUT0=4'hA, OUT0_VALID=1, OUT1_VALID=0; CNT0=1 (feature on).
- OUT0_READY=0; push 4'h1 then 4'h2 to lane 0 -> IN_READY=0 with CTRL=0. With CTRL=1 -> IN_READY=1; push 4'h3 -> OUT1=4'h3 next cycle, lane 0 unchanged.
- Lane 0 full, OUT0_READY=1 and CTRL=0 push in the same cycle -> IN_READY=0 that cycle. Next cycle OUT0=4'h2, IN_READY=1. Subsequent push+pop each cycle keeps OUT0_VALID=1 with count unchanged.
- Interleave CTRL=0,1,0,1 with IN0=1,2,3,4, consumers always ready -> OUT0 shows 1 then 3; OUT1 shows 2 then 4; no word lost or duplicated.
- Fill both lanes with 4 words total, assert RST for one cycle -> both VALID=0, OUT0=OUT1=0, IN_READY=1 next cycle, CNT0=CNT1=0.
- Feature on, CNT_W=4: 17 pushes to lane 1 -> CNT1=1 (wrapped), CNT0=0. Feature off -> CNT0=CNT1=0 throughout.
